// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bundle between the multicycle FSM and the RV32I datapath.
// The master side is the FSM: it takes the instruction and zero flag and drives every control output.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic [3:0]       state;
  logic             regiwrite;
  logic             memtoreg;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             pcwrite;
  logic             alusrc;
  logic [1:0]       aluop;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, zero,
    output state, regiwrite, memtoreg, memread, memwrite, irwrite,
           pcwrite, alusrc, aluop, halted, retired
  );

  modport slave (
    output instr, zero,
    input  state, regiwrite, memtoreg, memread, memwrite, irwrite,
           pcwrite, alusrc, aluop, halted, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback,
// halts on an illegal opcode and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'b0000,
    DECODE   = 4'b0001,
    MEMADR   = 4'b0010,
    MEMREAD  = 4'b0011,
    MEMWRITE = 4'b0100,
    EXECUTE  = 4'b0101,
    ALUWB    = 4'b0110,
    MEMWB    = 4'b0111,
    BRANCH   = 4'b1000,
    HALT     = 4'b1111
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic regiwrite_raw, memread_raw, memwrite_raw, pcwrite_raw;
  logic memtoreg_d, irwrite_d, alusrc_d;
  logic [1:0] aluop_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // NOTE: every output of this block gets a default first; any path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d       = FETCH;
    opcode_d      = opcode_q;
    halted_d      = halted_q;
    retired_d     = retired_q;
    regiwrite_raw = 1'b0;
    memread_raw   = 1'b0;
    memwrite_raw  = 1'b0;
    pcwrite_raw   = 1'b0;
    memtoreg_d    = 1'b0;
    irwrite_d     = 1'b0;
    alusrc_d      = 1'b0;
    aluop_d       = 2'b00;

    unique case (state_q)
      FETCH: begin
        irwrite_d   = 1'b1;
        pcwrite_raw = 1'b1;
        opcode_d    = bus.instr[6:0];
        state_d     = DECODE;
      end
      DECODE: begin
        if (opcode_q == OP_LW || opcode_q == OP_SW) begin
          state_d = MEMADR;
        end else if (opcode_q == OP_R || opcode_q == OP_I) begin
          state_d = EXECUTE;
        end else if (opcode_q == OP_BEQ) begin
          state_d = BRANCH;
        end else begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
      MEMADR: begin
        alusrc_d = 1'b1;
        aluop_d  = 2'b00;
        state_d  = (opcode_q == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        memread_raw = 1'b1;
        state_d     = MEMWB;
      end
      MEMWB: begin
        regiwrite_raw = 1'b1;
        memtoreg_d    = 1'b1;
        memread_raw   = 1'b1;
        retired_d     = retired_q + CNT_W'(1);
      end
      MEMWRITE: begin
        memwrite_raw = 1'b1;
        retired_d    = retired_q + CNT_W'(1);
      end
      EXECUTE: begin
        alusrc_d = (opcode_q != OP_R);
        aluop_d  = (opcode_q == OP_R) ? 2'b10 : 2'b11;
        state_d  = ALUWB;
      end
      ALUWB: begin
        // Operand select and op stay as in EXECUTE so the result is stable while written.
        regiwrite_raw = 1'b1;
        alusrc_d      = (opcode_q != OP_R);
        aluop_d       = (opcode_q == OP_R) ? 2'b10 : 2'b11;
        retired_d     = retired_q + CNT_W'(1);
      end
      BRANCH: begin
        aluop_d     = 2'b01;
        pcwrite_raw = bus.zero;
        retired_d   = retired_q + CNT_W'(1);
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write-type strobes are gated by reset so a reset landing mid-writeback is harmless.
  assign bus.regiwrite = regiwrite_raw & ~reset;
  assign bus.memread   = memread_raw   & ~reset;
  assign bus.memwrite  = memwrite_raw  & ~reset;
  assign bus.pcwrite   = pcwrite_raw   & ~reset;
  assign bus.memtoreg  = memtoreg_d;
  assign bus.irwrite   = irwrite_d;
  assign bus.alusrc    = alusrc_d;
  assign bus.aluop     = aluop_d;
  assign bus.state     = state_q;
  assign bus.halted    = halted_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: the stimulus side pushes the expected per-cycle control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;

  localparam logic [3:0] S_F = 4'h0, S_D = 4'h1, S_MA = 4'h2, S_MR = 4'h3,
                         S_MW = 4'h4, S_EX = 4'h5, S_AW = 4'h6, S_MB = 4'h7,
                         S_BR = 4'h8, S_H = 4'hF;

  typedef struct packed {
    logic [3:0]       state;
    logic             regiwrite;
    logic             memtoreg;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             pcwrite;
    logic             alusrc;
    logic [1:0]       aluop;
    logic             halted;
    logic [CNT_W-1:0] retired;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0] rcount;

  multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] st, input logic rw, m2r, mr, mw, ir, pc, src,
                              input logic [1:0] op, input logic h, input logic [CNT_W-1:0] ret);
    exp_t e;
    e.state = st; e.regiwrite = rw; e.memtoreg = m2r; e.memread = mr; e.memwrite = mw;
    e.irwrite = ir; e.pcwrite = pc; e.alusrc = src; e.aluop = op; e.halted = h; e.retired = ret;
    return e;
  endfunction

  // One clock cycle: drive inputs, record the expected outputs for that cycle, advance.
  task automatic run_cycle(input exp_t e, input logic [31:0] ins, input logic z);
    bus.instr = ins;
    bus.zero  = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: each instruction class walks a fixed list of phases; instr is
  // junk outside fetch and zero is junk outside the branch phase.
  task automatic issue(input logic [31:0] ins, input logic z);
    logic [6:0] op;
    op = ins[6:0];
    run_cycle(mk(S_F, 0,0,0,0,1,1,0, 2'b00, 0, rcount), ins, rbit());
    run_cycle(mk(S_D, 0,0,0,0,0,0,0, 2'b00, 0, rcount), $urandom(), rbit());
    case (op)
      7'b0000011: begin
        run_cycle(mk(S_MA, 0,0,0,0,0,0,1, 2'b00, 0, rcount), $urandom(), rbit());
        run_cycle(mk(S_MR, 0,0,1,0,0,0,0, 2'b00, 0, rcount), $urandom(), rbit());
        run_cycle(mk(S_MB, 1,1,1,0,0,0,0, 2'b00, 0, rcount), $urandom(), rbit());
        rcount = rcount + 1'b1;
      end
      7'b0100011: begin
        run_cycle(mk(S_MA, 0,0,0,0,0,0,1, 2'b00, 0, rcount), $urandom(), rbit());
        run_cycle(mk(S_MW, 0,0,0,1,0,0,0, 2'b00, 0, rcount), $urandom(), rbit());
        rcount = rcount + 1'b1;
      end
      7'b0110011: begin
        run_cycle(mk(S_EX, 0,0,0,0,0,0,0, 2'b10, 0, rcount), $urandom(), rbit());
        run_cycle(mk(S_AW, 1,0,0,0,0,0,0, 2'b10, 0, rcount), $urandom(), rbit());
        rcount = rcount + 1'b1;
      end
      7'b0010011: begin
        run_cycle(mk(S_EX, 0,0,0,0,0,0,1, 2'b11, 0, rcount), $urandom(), rbit());
        run_cycle(mk(S_AW, 1,0,0,0,0,0,1, 2'b11, 0, rcount), $urandom(), rbit());
        rcount = rcount + 1'b1;
      end
      7'b1100011: begin
        run_cycle(mk(S_BR, 0,0,0,0,0,z,0, 2'b01, 0, rcount), $urandom(), z);
        rcount = rcount + 1'b1;
      end
      default: begin
        repeat (20) run_cycle(mk(S_H, 0,0,0,0,0,0,0, 2'b00, 1, rcount), $urandom(), rbit());
      end
    endcase
  endtask

  // Monitor: one expected control word per non-reset cycle.
  always @(negedge clk) begin
    exp_t got, want;
    if (!reset && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = mk(bus.state, bus.regiwrite, bus.memtoreg, bus.memread, bus.memwrite,
                bus.irwrite, bus.pcwrite, bus.alusrc, bus.aluop, bus.halted, bus.retired);
      check($sformatf("cycle state=%h", want.state), 32'(got), 32'(want));
    end
  end

  logic [6:0] ops[5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};

  initial begin
    logic [31:0] r;
    reset = 1'b1; bus.instr = '0; bus.zero = 1'b0; rcount = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(bus.state), 32'(S_F));
    check("reset retired", 32'(bus.retired), 32'd0);
    check("reset halted", 32'(bus.halted), 32'd0);
    reset = 1'b0;

    // Reach ALUWB with an addi, then reset across it: no write, no retirement.
    run_cycle(mk(S_F,  0,0,0,0,1,1,0, 2'b00, 0, rcount), 32'h00A00093, 1'b0);
    run_cycle(mk(S_D,  0,0,0,0,0,0,0, 2'b00, 0, rcount), $urandom(), 1'b0);
    run_cycle(mk(S_EX, 0,0,0,0,0,0,1, 2'b11, 0, rcount), $urandom(), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst mid-wb state", 32'(bus.state), 32'(S_AW));
    check("rst mid-wb regiwrite", 32'(bus.regiwrite), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst 2nd cycle regiwrite", 32'(bus.regiwrite), 32'd0);
    @(posedge clk); #1;
    check("post-rst state", 32'(bus.state), 32'(S_F));
    check("post-rst retired", 32'(bus.retired), 32'd0);
    reset = 1'b0;

    issue(32'h00A00093, 1'b0);
    issue(32'h0000A103, 1'b0);
    issue(32'h0020A023, 1'b0);
    issue(32'h00208463, 1'b1);
    issue(32'h00208463, 1'b0);
    repeat (17) issue(32'h002081B3, 1'b0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom();
      issue({r[31:7], ops[$urandom_range(0, 4)]}, rbit());
    end

    issue(32'hFFFFFFFF, 1'b0);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("halt cleared by reset", 32'(bus.halted), 32'd0);
    check("state after halt reset", 32'(bus.state), 32'(S_F));
    check("retired after halt reset", 32'(bus.retired), 32'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle control unit for the RV32I datapath; sits directly upstream of the register bank.
- Generates the 4-bit `state` and the `regiwrite`/`memtoreg` strobes the register bank consumes. The register bank writes on the clock edge that ends a cycle in state 0110 (ALU writeback) or state 0111 (memory writeback).
- Also drives the memory, PC, instruction-register and ALU controls, flags an illegal opcode by halting, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  current instruction word from instruction memory; sampled in FETCH.
- zero  input  1  ALU zero flag; consulted only in BRANCH.
- state  output  4  registered FSM state; feeds the register bank directly.
- regiwrite  output  1  register-bank write enable.
- memtoreg  output  1  writeback source select: 1 = memory read data, 0 = ALU result.
- memread  output  1  data-memory read strobe.
- memwrite  output  1  data-memory write strobe.
- irwrite  output  1  instruction-register load.
- pcwrite  output  1  PC update enable.
- alusrc  output  1  ALU operand B select: 1 = immediate, 0 = rs2 data.
- aluop  output  2  ALU operation: 00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
- halted  output  1  sticky illegal-opcode flag.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- State encoding:
  - FETCH 0000, DECODE 0001, MEMADR 0010, MEMREAD 0011, MEMWRITE 0100.
  - EXECUTE 0101, ALUWB 0110, MEMWB 0111, BRANCH 1000, HALT 1111.
  - Encodings 1001–1110 are unused; if reached, go to FETCH on the next edge.
- Reset values: state=FETCH, opcode_q=0, halted=0, retired=0. All other outputs are decoded from state.
- Reset masking: while reset=1, regiwrite, memwrite, memread and pcwrite are forced to 0. This holds even if state is ALUWB/MEMWB, so a reset applied mid-writeback causes no register or memory write. The next state after a reset edge is FETCH.
- FETCH: irwrite=1, pcwrite=1. opcode_q <= instr[6:0]. Next state is DECODE.
- DECODE: branches on opcode_q.
  - 0000011 (lw) or 0100011 (sw) -> MEMADR.
  - 0110011 (R-type) or 0010011 (I-type ALU) -> EXECUTE.
  - 1100011 (beq) -> BRANCH.
  - Any other opcode -> HALT.
- MEMADR: alusrc=1, aluop=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: memread=1. Next state is MEMWB.
- MEMWB: regiwrite=1, memtoreg=1, memread=1. Next state is FETCH.
- MEMWRITE: memwrite=1. Next state is FETCH.
- EXECUTE:
  - R-type: alusrc=0, aluop=10.
  - I-type: alusrc=1, aluop=11.
  - Next state is ALUWB.
- ALUWB: regiwrite=1, memtoreg=0. aluop and alusrc hold their EXECUTE values so the ALU result stays stable through writeback. Next state is FETCH.
- BRANCH: aluop=01, alusrc=0. pcwrite is combinational and equals zero. Next state is FETCH.
- HALT:
  - halted=1; all strobes are 0; the FSM stays in HALT until reset.
  - halted is set on the edge that enters HALT.
- Defaults: in any state not listed above, each strobe is 0, alusrc=0 and aluop=00.
- retired counter:
  - Increments by 1 on each edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W.
  - Reset takes priority over an increment on the same edge.
- Latency per instruction: lw 5 cycles; sw, R-type and I-type 4 cycles; beq 3 cycles.
- regiwrite is never asserted outside state 0110/0111, so the register bank's state gating and regiwrite agree.
- opcode_q is loaded only in FETCH. instr may change freely in every other state.

Test Plan:
- Reset held 2 cycles with state forced to ALUWB, then released -> regiwrite=0 throughout reset; state=0000, retired=0 after release.
- instr=0x00A00093 (addi x1,x0,10) -> state sequence 0000,0001,0101,0110,0000. aluop=11, alusrc=1 in 0101/0110; regiwrite=1 only in 0110; retired=1.
- instr=0x0000A103 (lw) -> sequence 0000,0001,0010,0011,0111,0000. memread=1 in 0011/0111; memtoreg=1 and regiwrite=1 in 0111; retired=1.
- instr=0x0020A023 (sw) -> sequence 0000,0001,0010,0100,0000. memwrite=1 only in 0100; regiwrite=0 throughout.
- instr=0x00208463 (beq) with zero=1, then again with zero=0 -> pcwrite=1 in 1000 only when zero=1; each pass takes 3 cycles; retired increments by 1 each time.
- instr=0xFFFFFFFF -> HALT (1111) after DECODE, halted=1 and held for 20 cycles with all strobes 0. With CNT_W=4 preloaded via 16 R-type instructions, retired wraps 15->0.
